// File: rtl/kmeans_update_acc_k3_d3.sv
// kmeans_update_acc_k3_d3: per-centroid sum/count accumulator with sequential restoring-divide centroid update
module kmeans_update_acc_k3_d3 #(
    parameter int input_data_width = 16,
    parameter int count_width      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [input_data_width-1:0] input_data0,
    input  logic [input_data_width-1:0] input_data1,
    input  logic [input_data_width-1:0] input_data2,
    input  logic [1:0]                  selected_centroid,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [1:0]                  out_idx,
    output logic [input_data_width-1:0] out_data0,
    output logic [input_data_width-1:0] out_data1,
    output logic [input_data_width-1:0] out_data2,
    output logic [count_width-1:0]      out_count,
    output logic                        out_empty,
    output logic                        overflow
);
    localparam int sw  = input_data_width + count_width;
    localparam int cnw = $clog2(sw);
    localparam logic [2:0] s_acc = 3'd0, s_load = 3'd1, s_div = 3'd2, s_emit = 3'd3, s_clear = 3'd4;
    logic [2:0]                  state;
    logic [1:0]                  k;
    logic [cnw-1:0]              cnt;
    logic [sw-1:0]               sum [3][3];
    logic [count_width-1:0]      count [3];
    logic [sw-1:0]               quo [3];
    logic [sw-1:0]               quo_n [3];
    logic [count_width-1:0]      rem [3];
    logic [count_width-1:0]      rem_n [3];
    logic [count_width:0]        sh [3];
    logic [count_width-1:0]      dvs;
    logic [input_data_width-1:0] din [3];
    logic [input_data_width-1:0] dout [3];
    logic                        hit;
    logic                        sat;
    assign din[0]    = input_data0;
    assign din[1]    = input_data1;
    assign din[2]    = input_data2;
    assign out_data0 = dout[0];
    assign out_data1 = dout[1];
    assign out_data2 = dout[2];
    assign in_ready  = state == s_acc;
    assign out_valid = state == s_emit;
    assign hit       = in_valid && in_ready && selected_centroid != 2'd3;
    assign sat       = hit && &count[selected_centroid];
    // Remainder after a successful subtract is below the divisor, so the low count_width bits suffice
    always_comb begin
        for (int j = 0; j < 3; j++) begin
            sh[j]    = {rem[j], quo[j][sw-1]};
            rem_n[j] = sh[j] >= {1'b0, dvs} ? sh[j][count_width-1:0] - dvs : sh[j][count_width-1:0];
            quo_n[j] = {quo[j][sw-2:0], sh[j] >= {1'b0, dvs}};
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= s_acc;
            k         <= 2'd0;
            cnt       <= '0;
            dvs       <= '0;
            overflow  <= 1'b0;
            out_idx   <= 2'd0;
            out_count <= '0;
            out_empty <= 1'b0;
            for (int j = 0; j < 3; j++) begin
                dout[j]  <= '0;
                quo[j]   <= '0;
                rem[j]   <= '0;
                count[j] <= '0;
                for (int i = 0; i < 3; i++) sum[j][i] <= '0;
            end
        end else begin
            case (state)
                s_acc: begin
                    if (sat) overflow <= 1'b1;
                    if (hit && !sat) begin
                        count[selected_centroid] <= count[selected_centroid] + count_width'(1);
                        for (int j = 0; j < 3; j++)
                            sum[selected_centroid][j] <= sum[selected_centroid][j] + sw'(din[j]);
                    end
                    if (in_valid && in_last) begin
                        state <= s_load;
                        k     <= 2'd0;
                    end
                end
                s_load: begin
                    dvs   <= count[k];
                    cnt   <= '0;
                    state <= s_div;
                    for (int j = 0; j < 3; j++) begin
                        quo[j] <= sum[k][j];
                        rem[j] <= '0;
                    end
                end
                s_div: begin
                    cnt <= cnt + cnw'(1);
                    for (int j = 0; j < 3; j++) begin
                        quo[j] <= quo_n[j];
                        rem[j] <= rem_n[j];
                    end
                    if (cnt == cnw'(sw - 1)) begin
                        state     <= s_emit;
                        out_idx   <= k;
                        out_count <= dvs;
                        out_empty <= dvs == '0;
                        for (int j = 0; j < 3; j++)
                            dout[j] <= dvs == '0 ? '0 : quo_n[j][input_data_width-1:0];
                    end
                end
                s_emit: begin
                    state <= k == 2'd2 ? s_clear : s_load;
                    k     <= k == 2'd2 ? 2'd0 : k + 2'd1;
                end
                s_clear: begin
                    state <= s_acc;
                    for (int j = 0; j < 3; j++) begin
                        count[j] <= '0;
                        for (int i = 0; i < 3; i++) sum[j][i] <= '0;
                    end
                end
                default: state <= s_acc;
            endcase
        end
    end
endmodule

// File: tb/tb_kmeans_update_acc_k3_d3.sv
// tb_kmeans_update_acc_k3_d3: default and count_width=2 instances checked against a cycle-level model
module tb_kmeans_update_acc_k3_d3;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_last = 0;
    logic [15:0] d0 = 0, d1 = 0, d2 = 0;
    logic [1:0]  sel = 0;
    logic        rdy [2];
    logic        ov [2];
    logic        oe [2];
    logic        of [2];
    logic [1:0]  oi [2];
    logic [15:0] od [2][3];
    logic [15:0] oc0;
    logic [1:0]  oc1;
    always #5 clk = ~clk;
    kmeans_update_acc_k3_d3 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .input_data0(d0), .input_data1(d1), .input_data2(d2), .selected_centroid(sel),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_idx(oi[0]),
        .out_data0(od[0][0]), .out_data1(od[0][1]), .out_data2(od[0][2]),
        .out_count(oc0), .out_empty(oe[0]), .overflow(of[0]));
    kmeans_update_acc_k3_d3 #(.input_data_width(16), .count_width(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .input_data0(d0), .input_data1(d1), .input_data2(d2), .selected_centroid(sel),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_idx(oi[1]),
        .out_data0(od[1][0]), .out_data1(od[1][1]), .out_data2(od[1][2]),
        .out_count(oc1), .out_empty(oe[1]), .overflow(of[1]));
    localparam int SWV [2] = '{32, 18};
    localparam int CMAX [2] = '{65535, 3};
    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_en = 0;
    int m_sum [2][3][3];
    int m_cnt [2][3];
    int m_t [2] = '{-1, -1};
    int m_ovf [2];
    int acc_cyc [2];
    int e_data [2][3][3];
    int e_cnt [2][3];
    int x_idx [2];
    int x_data [2][3];
    int x_cnt [2];
    int x_empty [2];
    int cap_data [2][3][3];
    int cap_cnt [2][3];
    int cap_empty [2][3];
    int cap_t [2][3];
    int rdy_t [2];
    int n_beat [2];
    bit prev_rdy [2];
    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %0d expected %0d", nm, i, cyc, act, exp);
        end
    endtask
    function automatic int emit_k(input int i);
        for (int k = 0; k < 3; k++) if (m_t[i] == (k + 1) * (SWV[i] + 2)) return k;
        return -1;
    endfunction
    // Model: plain sums/counts, pass results computed with integer division at in_last
    always @(posedge clk) begin
        int dv [3];
        int ek;
        dv[0] = d0; dv[1] = d1; dv[2] = d2;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_t[i] = -1; m_ovf[i] = 0; x_idx[i] = 0; x_cnt[i] = 0; x_empty[i] = 0;
                for (int k = 0; k < 3; k++) begin
                    m_cnt[i][k] = 0; x_data[i][k] = 0;
                    for (int j = 0; j < 3; j++) m_sum[i][k][j] = 0;
                end
            end else if (m_t[i] >= 0) begin
                m_t[i]++;
                ek = emit_k(i);
                if (m_t[i] == 3 * (SWV[i] + 2) + 2) m_t[i] = -1;
                else if (ek >= 0) begin
                    x_idx[i] = ek; x_cnt[i] = e_cnt[i][ek]; x_empty[i] = e_cnt[i][ek] == 0;
                    for (int j = 0; j < 3; j++) x_data[i][j] = e_data[i][ek][j];
                end
            end else if (in_valid) begin
                if (sel != 2'd3) begin
                    if (m_cnt[i][sel] == CMAX[i]) m_ovf[i] = 1;
                    else begin
                        m_cnt[i][sel]++;
                        for (int j = 0; j < 3; j++) m_sum[i][sel][j] += dv[j];
                    end
                end
                if (in_last) begin
                    for (int k = 0; k < 3; k++) begin
                        e_cnt[i][k] = m_cnt[i][k];
                        for (int j = 0; j < 3; j++) begin
                            e_data[i][k][j] = m_cnt[i][k] != 0 ? m_sum[i][k][j] / m_cnt[i][k] : 0;
                            m_sum[i][k][j] = 0;
                        end
                        m_cnt[i][k] = 0;
                    end
                    m_t[i] = 1;
                    acc_cyc[i] = cyc;
                end
            end
        end
        cyc++;
    end
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("in_ready", i, rdy[i], m_t[i] < 0);
                chk("out_valid", i, ov[i], emit_k(i) >= 0);
                chk("out_idx", i, oi[i], x_idx[i]);
                for (int j = 0; j < 3; j++) chk("out_data", i, od[i][j], x_data[i][j]);
                chk("out_count", i, i == 1 ? 32'(oc1) : 32'(oc0), x_cnt[i]);
                chk("out_empty", i, oe[i], x_empty[i]);
                chk("overflow", i, of[i], m_ovf[i]);
                if (ov[i]) begin
                    n_beat[i]++;
                    cap_cnt[i][oi[i]] = i == 1 ? 32'(oc1) : 32'(oc0);
                    cap_empty[i][oi[i]] = oe[i];
                    cap_t[i][oi[i]] = cyc - acc_cyc[i];
                    for (int j = 0; j < 3; j++) cap_data[i][oi[i]][j] = od[i][j];
                end
                if (rdy[i] && !prev_rdy[i]) rdy_t[i] = cyc - acc_cyc[i];
                prev_rdy[i] = rdy[i];
            end
        end
    end
    task automatic point(input logic [1:0] s, input int a, input int b, input int c, input bit l);
        sel = s; d0 = 16'(a); d1 = 16'(b); d2 = 16'(c);
        in_valid = 1; in_last = l;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask
    task automatic wait_ready();
        int n = 0;
        while (!(rdy[0] && rdy[1]) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_ready_timeout", 0, n < 400, 1);
        @(negedge clk); #1;
    endtask
    task automatic lit_beat(input int i, input int k, input int a, input int b, input int c, input int n, input int e);
        chk("lit_d0", i, cap_data[i][k][0], a);
        chk("lit_d1", i, cap_data[i][k][1], b);
        chk("lit_d2", i, cap_data[i][k][2], c);
        chk("lit_count", i, cap_cnt[i][k], n);
        chk("lit_empty", i, cap_empty[i][k], e);
    endtask
    initial begin
        int nb;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk_en = 1;
        chk("rst_ready", 0, rdy[0], 1);
        chk("rst_valid", 0, ov[0], 0);
        chk("rst_overflow", 0, of[0], 0);
        chk("rst_count", 0, oc0, 0);
        point(0, 10, 20, 30, 0);
        point(0, 12, 22, 32, 1);
        wait_ready();
        lit_beat(0, 0, 11, 21, 31, 2, 0);
        lit_beat(0, 1, 0, 0, 0, 0, 1);
        lit_beat(0, 2, 0, 0, 0, 0, 1);
        lit_beat(1, 0, 11, 21, 31, 2, 0);
        chk("t_emit0", 0, cap_t[0][0], 34);
        chk("t_emit1", 0, cap_t[0][1], 68);
        chk("t_emit2", 0, cap_t[0][2], 102);
        chk("t_ready", 0, rdy_t[0], 104);
        chk("t_ready", 1, rdy_t[1], 62);
        point(1, 1, 0, 5, 0);
        point(1, 2, 0, 6, 1);
        wait_ready();
        lit_beat(0, 1, 1, 0, 5, 2, 0);
        lit_beat(0, 0, 0, 0, 0, 0, 1);
        chk("t_ready2", 0, rdy_t[0], 104);
        point(3, 100, 100, 100, 0);
        point(2, 4, 4, 4, 1);
        repeat (10) @(posedge clk);
        #1 point(0, 50, 50, 50, 0);
        wait_ready();
        lit_beat(0, 2, 4, 4, 4, 1, 0);
        chk("idx3_k0", 0, cap_cnt[0][0], 0);
        chk("idx3_k1", 0, cap_cnt[0][1], 0);
        point(0, 2, 2, 2, 1);
        wait_ready();
        lit_beat(0, 0, 2, 2, 2, 1, 0);
        lit_beat(1, 0, 2, 2, 2, 1, 0);
        nb = n_beat[0];
        point(1, 9, 9, 9, 1);
        repeat (19) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        chk("ready_after_rst", 0, rdy[0], 1);
        repeat (40) @(posedge clk);
        #1 chk("no_beat_after_rst", 0, n_beat[0], nb);
        repeat (3) point(0, 8, 8, 8, 0);
        point(0, 8, 8, 8, 1);
        wait_ready();
        lit_beat(1, 0, 8, 8, 8, 3, 0);
        lit_beat(0, 0, 8, 8, 8, 4, 0);
        chk("rst_cleared_k1", 0, cap_cnt[0][1], 0);
        chk("sat_overflow", 1, of[1], 1);
        chk("nosat_overflow", 0, of[0], 0);
        point(2, 3, 3, 3, 1);
        wait_ready();
        lit_beat(1, 2, 3, 3, 3, 1, 0);
        chk("sticky_overflow", 1, of[1], 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
